// File: rtl/me_frame_sequencer.sv
// me_frame_sequencer: walks a frame of macroblocks through the ME core req/ack handshake, stores results and keeps SAD statistics
module me_frame_sequencer #(
    parameter int MB_COLS = 4,
    parameter int MB_ROWS = 3,
    parameter int TIMEOUT = 4096,
    parameter int RES_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        mb_x,
    output logic [7:0]        mb_y,
    output logic              me_req,
    input  logic              me_ack,
    input  logic [15:0]       me_min_sad,
    input  logic [11:0]       me_min_mvec,
    output logic              res_we,
    output logic [RES_AW-1:0] res_addr,
    output logic [27:0]       res_data,
    output logic [19:0]       sad_total,
    output logic [15:0]       sad_best,
    output logic [RES_AW-1:0] best_idx
);
    localparam int TW   = $clog2(TIMEOUT);
    localparam int LAST = MB_COLS * MB_ROWS - 1;
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t            r_state;
    logic [TW-1:0]     r_cnt;
    logic [RES_AW-1:0] r_idx;
    logic [20:0]       w_sum;
    assign w_sum = {1'b0, sad_total} + {5'b0, me_min_sad};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mb_x      <= '0;
            mb_y      <= '0;
            me_req    <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
            sad_total <= '0;
            sad_best  <= '0;
            best_idx  <= '0;
        end else begin
            done   <= 1'b0;
            res_we <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    err       <= 1'b0;
                    mb_x      <= '0;
                    mb_y      <= '0;
                    r_idx     <= '0;
                    r_cnt     <= '0;
                    sad_total <= '0;
                    sad_best  <= '1;
                    best_idx  <= '0;
                    me_req    <= 1'b1;
                    r_state   <= REQ;
                end
                // ack beats the terminal count when both land on the same edge
                REQ: if (me_ack) begin
                    me_req    <= 1'b0;
                    res_we    <= 1'b1;
                    res_addr  <= r_idx;
                    res_data  <= {me_min_mvec, me_min_sad};
                    sad_total <= w_sum[20] ? '1 : w_sum[19:0];
                    if (me_min_sad < sad_best) begin
                        sad_best <= me_min_sad;
                        best_idx <= r_idx;
                    end
                    r_state   <= GAP;
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    err     <= 1'b1;
                    me_req  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                GAP: if (r_idx == RES_AW'(LAST)) begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    mb_x    <= (mb_x == 8'(MB_COLS - 1)) ? 8'd0 : mb_x + 8'd1;
                    mb_y    <= (mb_x == 8'(MB_COLS - 1)) ? mb_y + 8'd1 : mb_y;
                    r_idx   <= r_idx + 1'b1;
                    r_cnt   <= '0;
                    me_req  <= 1'b1;
                    r_state <= REQ;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_frame_sequencer.sv
// tb_me_frame_sequencer: randomized frames against a per-macroblock reference of addresses, data and statistics
module tb_me_frame_sequencer;
    localparam int C = 8, R = 4, TO = 16, AW = 8, N = C * R;
    logic          clk = 0, rst_n = 0, start = 0, me_ack = 0;
    logic [15:0]   me_min_sad = 0;
    logic [11:0]   me_min_mvec = 0;
    logic          busy, done, err, me_req, res_we;
    logic [7:0]    mb_x, mb_y;
    logic [AW-1:0] res_addr, best_idx;
    logic [27:0]   res_data;
    logic [19:0]   sad_total;
    logic [15:0]   sad_best;
    int            n_chk = 0, n_fail = 0;
    me_frame_sequencer #(.MB_COLS(C), .MB_ROWS(R), .TIMEOUT(TO), .RES_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .mb_x(mb_x), .mb_y(mb_y), .me_req(me_req), .me_ack(me_ack),
        .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .res_we(res_we),
        .res_addr(res_addr), .res_data(res_data), .sad_total(sad_total),
        .sad_best(sad_best), .best_idx(best_idx)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] sad_for(input int mode, input int k);
        if (mode == 1) return 16'(100 + k);
        if (mode == 2) return 16'hFFFF;
        if (mode == 3) return (k == 0) ? 16'd50 : (k < 3) ? 16'd30 : (k == 3) ? 16'd40 : 16'(30 + $urandom_range(0, 500));
        return 16'($urandom);
    endfunction
    // One frame driven at negedges; abort_at selects a macroblock that is never acked
    task automatic run_frame(input int mode, input int abort_at);
        int total, bidx, d, cnt;
        logic [15:0] best, s;
        logic [11:0] mv;
        start = 1;
        @(negedge clk);
        start = 0;
        check("start_busy", busy, 1);
        check("start_err", err, 0);
        check("start_total", sad_total, 0);
        check("start_best", sad_best, 16'hFFFF);
        check("start_bidx", best_idx, 0);
        total = 0;
        best = 16'hFFFF;
        bidx = 0;
        for (int k = 0; k < N; k++) begin
            check("req_hi", me_req, 1);
            check("mb_x", mb_x, k % C);
            check("mb_y", mb_y, k / C);
            check("we_lo", res_we, 0);
            check("done_lo", done, 0);
            if (k == abort_at) begin
                cnt = 0;
                for (int j = 0; j < 3 * TO && me_req; j++) begin
                    cnt++;
                    check("to_we", res_we, 0);
                    @(negedge clk);
                end
                check("to_cycles", cnt, TO);
                check("to_err", err, 1);
                check("to_busy", busy, 0);
                check("to_done", done, 0);
                check("to_total", sad_total, total);
                return;
            end
            d = $urandom_range(0, 6);
            repeat (d) begin
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                start = 0;
                check("hold_req", me_req, 1);
                check("hold_x", mb_x, k % C);
                check("hold_busy", busy, 1);
            end
            s = sad_for(mode, k);
            mv = 12'($urandom);
            me_min_sad = s;
            me_min_mvec = mv;
            me_ack = 1;
            @(negedge clk);
            me_ack = 0;
            if (s < best) begin
                best = s;
                bidx = k;
            end
            total = (total + s > 20'hFFFFF) ? 20'hFFFFF : total + s;
            check("wr_we", res_we, 1);
            check("wr_req", me_req, 0);
            check("wr_addr", res_addr, k);
            check("wr_data", res_data, {mv, s});
            check("sad_total", sad_total, total);
            check("sad_best", sad_best, best);
            check("best_idx", best_idx, bidx);
            me_ack = 1'($urandom_range(0, 1));
            me_min_sad = 0;
            @(negedge clk);
            me_ack = 0;
            check("gap_we", res_we, 0);
            if (k == N - 1) begin
                check("done_hi", done, 1);
                check("end_busy", busy, 0);
                check("end_req", me_req, 0);
                repeat (2) @(negedge clk);
                check("done_1cyc", done, 0);
                check("hold_total", sad_total, total);
                check("hold_best", sad_best, best);
                check("hold_mbx", mb_x, C - 1);
                check("hold_mby", mb_y, R - 1);
            end
        end
    endtask
    initial begin
        start = 1;
        me_ack = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", me_req, 0);
        check("rst_we", res_we, 0);
        check("rst_outs", {done, err, mb_x, mb_y, res_addr, best_idx}, 0);
        check("rst_data", res_data, 0);
        check("rst_stats", {sad_total, sad_best}, 0);
        start = 0;
        me_ack = 0;
        rst_n = 1;
        @(negedge clk);
        run_frame(1, -1);
        run_frame(3, -1);
        check("tie_best", sad_best, 30);
        check("tie_idx", best_idx, 1);
        run_frame(2, -1);
        check("sat_total", sad_total, 20'hFFFFF);
        run_frame(0, 2);
        run_frame(0, -1);
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("mid_rst_req", me_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_best", sad_best, 0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_done", done, 0);
            check("mid_rst_we", res_we, 0);
        end
        run_frame(0, -1);
        run_frame(0, $urandom_range(0, N - 1));
        run_frame(0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
